aes_key_expander: RTL and testbench

//  Iterative AES-128 key schedule and round-key store, one stage downstream of the AES control FSM.
//  On a key-change pulse it latches the cipher key as RK0, then derives RK1..RK10 at one round key per clock.
//  All 11 round keys sit in an internal bank; the datapath reads them by round index with 1-cycle latency.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_sbox.sv | 37 +++
 rtl/aes_key_expander.sv | 144 ++++++++++++++
 tb/tb_aes_key_expander.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Brief  : Shared types, round constants and GF(2^8) helpers for the AES key
//          schedule.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
    };

    // Out-of-range rounds yield 0 so the datapath can be evaluated while idle.
    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        if (rnd >= 4'd1 && rnd <= 4'd10) begin
            return RCON[rnd];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// Module : aes_sbox
// Brief  : Combinational AES S-box: multiplicative inverse in GF(2^8)
//          followed by the FIPS-197 affine transform.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] w_sq;
    logic [7:0] w_inv;

    // x^254 = x^-1 (and maps 0 to 0), built by square-and-multiply.
    always_comb begin
        w_sq  = din;
        w_inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            w_sq  = gf_mul(w_sq, w_sq);
            w_inv = gf_mul(w_inv, w_sq);
        end
        dout = w_inv
             ^ {w_inv[6:0], w_inv[7]}
             ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]}
             ^ {w_inv[3:0], w_inv[7:4]}
             ^ 8'h63;
    end

endmodule

`default_nettype wire

// File: rtl/aes_key_expander.sv
// ============================================================================
// Module : aes_key_expander
// Brief  : Iterative AES-128 key schedule (one round key per clock) with an
//          11-entry round-key bank and a registered read port.
//          Build option KEYEXP_ZEROIZE_EN: bank cleared on reset and on load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_load,
    input  logic [3:0]       rk_sel,
    output logic [KEY_W-1:0] rk_out,
    output logic             rk_valid,
    output logic             busy,
    output logic             keys_ready
);

    localparam logic [3:0] c_LAST_RK = 4'(NR_AES128);

    if (NR != NR_AES128 || KEY_W != 128) begin : g_bad_param
        $error("aes_key_expander supports only NR=10 and KEY_W=128");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_rnd;
    logic [3:0]       w_rnd_nxt;
    logic [KEY_W-1:0] r_bank [0:NR];

    logic [3:0]       w_prev_idx;
    logic [KEY_W-1:0] w_prev;
    word_t            w_rot;
    word_t            w_sub;
    word_t            w_t;
    word_t            w_n0, w_n1, w_n2, w_n3;
    logic [KEY_W-1:0] w_next_rk;
    logic             w_rd_valid;

    assign w_prev_idx = (r_rnd == 4'd0) ? 4'd0 : r_rnd - 4'd1;
    assign w_prev     = r_bank[w_prev_idx];
    assign w_rot      = {w_prev[23:0], w_prev[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (w_rot[8*i +: 8]),
            .dout (w_sub[8*i +: 8])
        );
    end

    assign w_t       = w_sub ^ {rcon_of(r_rnd), 24'h000000};
    assign w_n0      = w_prev[127:96] ^ w_t;
    assign w_n1      = w_prev[95:64]  ^ w_n0;
    assign w_n2      = w_prev[63:32]  ^ w_n1;
    assign w_n3      = w_prev[31:0]   ^ w_n2;
    assign w_next_rk = {w_n0, w_n1, w_n2, w_n3};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_rnd   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rnd   <= w_rnd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rnd_nxt   = r_rnd;
        if (key_load) begin
            w_state_nxt = EXPAND;
            w_rnd_nxt   = 4'd1;
        end else begin
            case (r_state)
                EXPAND: begin
                    if (r_rnd == c_LAST_RK) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_rnd_nxt = r_rnd + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Valid only for entries already written by the expansion in flight;
    // a load replaces the whole schedule, so nothing is valid on that edge.
    always_comb begin
        w_rd_valid = 1'b0;
        case (r_state)
            EXPAND:  w_rd_valid = (rk_sel < r_rnd);
            DONE:    w_rd_valid = (rk_sel <= c_LAST_RK);
            default: w_rd_valid = 1'b0;
        endcase
        if (key_load) begin
            w_rd_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef KEYEXP_ZEROIZE_EN
            for (int i = 0; i <= NR; i++) begin
                r_bank[i] <= '0;
            end
`endif
        end else if (key_load) begin
            r_bank[0] <= key_in;
`ifdef KEYEXP_ZEROIZE_EN
            for (int i = 1; i <= NR; i++) begin
                r_bank[i] <= '0;
            end
`endif
        end else if (r_state == EXPAND) begin
            r_bank[r_rnd] <= w_next_rk;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rk_out   <= '0;
            rk_valid <= 1'b0;
        end else begin
            rk_out   <= (rk_sel <= c_LAST_RK) ? r_bank[rk_sel] : '0;
            rk_valid <= w_rd_valid;
        end
    end

    assign busy       = (r_state == EXPAND);
    assign keys_ready = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expander.sv
// ============================================================================
// Module : tb_aes_key_expander
// Brief  : Self-checking bench for aes_key_expander with an independent key
//          schedule model and a read scoreboard (KEYEXP_ZEROIZE_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key_in;
    logic         key_load;
    logic [3:0]   rk_sel;
    logic [127:0] rk_out;
    logic         rk_valid;
    logic         busy;
    logic         keys_ready;

    aes_key_expander #(.NR(10), .KEY_W(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_load   (key_load),
        .rk_sel     (rk_sel),
        .rk_out     (rk_out),
        .rk_valid   (rk_valid),
        .busy       (busy),
        .keys_ready (keys_ready)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] c_FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        logic [127:0] rk;
        logic         v;
        logic         chk_rk;
    } exp_t;

    exp_t         sbq [$];
    exp_t         e;
    logic [7:0]   sb  [256];
    logic [127:0] mrk [11];
    int           n_checks = 0;
    int           n_fail   = 0;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // Inverse found by exhaustive search, then the bitwise affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int j = 0; j < 8; j++)
                s[j] = inv[j] ^ inv[(j+4)%8] ^ inv[(j+5)%8] ^ inv[(j+6)%8] ^ inv[(j+7)%8] ^ c[j];
            sb[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        cyc();
        key_load = 1'b0;
    endtask

    function automatic exp_t done_exp(input int sel);
        exp_t x;
        x.chk_rk = 1'b1;
        x.v      = (sel <= 10);
        x.rk     = (sel <= 10) ? mrk[sel] : 128'h0;
        return x;
    endfunction

    function automatic logic [127:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        reset = 1'b1; key_load = 1'b1; key_in = rnd_key(); rk_sel = 4'd0;
        cyc(); cyc();
        key_load = 1'b0;
        n_checks += 4;
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (keys_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", keys_ready); end
        if (rk_out !== 128'h0)   begin n_fail++; $display("FAIL reset_rk_out: got %h want 0", rk_out); end
        if (rk_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_rk_valid: got %b want 0", rk_valid); end
        reset = 1'b0;
        sbq.push_back('{rk: 128'h0, v: 1'b0, chk_rk: 1'b0});
        cyc();
        e = sbq.pop_front();
        n_checks += 2;
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
        if (rk_valid !== e.v)  begin n_fail++; $display("FAIL idle_rk_valid: got %b want %b", rk_valid, e.v); end
    endtask

    task automatic test_fips_expand();
        int nb = 0;
        int ready_at = -1;
        model_expand(c_FIPS_KEY);
        do_load(c_FIPS_KEY);
        for (int k = 1; k <= 14; k++) begin
            if (busy === 1'b1) nb++;
            if (keys_ready === 1'b1 && ready_at < 0) ready_at = k;
            cyc();
        end
        n_checks += 2;
        if (nb != 10)       begin n_fail++; $display("FAIL fips_busy_cycles: got %0d want 10", nb); end
        if (ready_at != 11) begin n_fail++; $display("FAIL fips_ready_cycle: got %0d want 11", ready_at); end
    endtask

    task automatic test_read_sweep();
        for (int s = 0; s < 16; s++) begin
            rk_sel = 4'(s);
            sbq.push_back(done_exp(s));
            cyc();
            e = sbq.pop_front();
            n_checks += 2;
            if (rk_out !== e.rk)  begin n_fail++; $display("FAIL sweep_rk[%0d]: got %h want %h", s, rk_out, e.rk); end
            if (rk_valid !== e.v) begin n_fail++; $display("FAIL sweep_valid[%0d]: got %b want %b", s, rk_valid, e.v); end
            if (s == 1) begin
                n_checks++;
                if (rk_out !== c_FIPS_RK1) begin n_fail++; $display("FAIL fips_rk1: got %h want %h", rk_out, c_FIPS_RK1); end
            end
            if (s == 10) begin
                n_checks++;
                if (rk_out !== c_FIPS_RK10) begin n_fail++; $display("FAIL fips_rk10: got %h want %h", rk_out, c_FIPS_RK10); end
            end
        end
    endtask

    task automatic test_reload_mid();
        int ready_at = -1;
        do_load(c_FIPS_KEY);
        for (int k = 1; k <= 4; k++) begin
            n_checks += 2;
            if (busy !== 1'b1)       begin n_fail++; $display("FAIL reload_busy[%0d]: got %b want 1", k, busy); end
            if (keys_ready !== 1'b0) begin n_fail++; $display("FAIL reload_ready[%0d]: got %b want 0", k, keys_ready); end
            cyc();
        end
        do_load(128'h0);
        model_expand(128'h0);
        for (int k = 1; k <= 12; k++) begin
            if (keys_ready === 1'b1 && ready_at < 0) ready_at = k;
            cyc();
        end
        n_checks++;
        if (ready_at != 11) begin n_fail++; $display("FAIL reload_ready_cycle: got %0d want 11", ready_at); end
        for (int s = 0; s <= 10; s++) begin
            rk_sel = 4'(s);
            sbq.push_back(done_exp(s));
            cyc();
            e = sbq.pop_front();
            n_checks += 2;
            if (rk_out !== e.rk)  begin n_fail++; $display("FAIL zero_rk[%0d]: got %h want %h", s, rk_out, e.rk); end
            if (rk_valid !== e.v) begin n_fail++; $display("FAIL zero_valid[%0d]: got %b want %b", s, rk_valid, e.v); end
            if (s == 10) begin
                n_checks++;
                if (rk_out !== c_ZERO_RK10) begin n_fail++; $display("FAIL zero_rk10: got %h want %h", rk_out, c_ZERO_RK10); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] k2;
        int ready_at = -1;
        do_load(rnd_key());
        cyc(); cyc(); cyc();
        reset = 1'b1; rk_sel = 4'd0;
        cyc();
        n_checks += 3;
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (keys_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", keys_ready); end
        if (rk_valid !== 1'b0)   begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", rk_valid); end
        reset = 1'b0;
        sbq.push_back('{rk: 128'h0, v: 1'b0, chk_rk: 1'b0});
        cyc();
        e = sbq.pop_front();
        n_checks++;
        if (rk_valid !== e.v) begin n_fail++; $display("FAIL rstmid_stale_valid: got %b want %b", rk_valid, e.v); end
        k2 = rnd_key();
        model_expand(k2);
        do_load(k2);
        for (int k = 1; k <= 12; k++) begin
            if (keys_ready === 1'b1 && ready_at < 0) ready_at = k;
            cyc();
        end
        n_checks++;
        if (ready_at != 11) begin n_fail++; $display("FAIL rstmid_ready_cycle: got %0d want 11", ready_at); end
        for (int s = 0; s <= 10; s++) begin
            rk_sel = 4'(s);
            sbq.push_back(done_exp(s));
            cyc();
            e = sbq.pop_front();
            n_checks += 2;
            if (rk_out !== e.rk)  begin n_fail++; $display("FAIL rstmid_rk[%0d]: got %h want %h", s, rk_out, e.rk); end
            if (rk_valid !== e.v) begin n_fail++; $display("FAIL rstmid_rkv[%0d]: got %b want %b", s, rk_valid, e.v); end
        end
    endtask

    task automatic test_midexp_read();
        int sels [12] = '{0, 3, 1, 2, 5, 4, 9, 10, 10, 11, 7, 0};
        logic [127:0] k3 = rnd_key();
        exp_t x;
        model_expand(k3);
        do_load(k3);
        for (int k = 1; k <= 12; k++) begin
            rk_sel   = 4'(sels[k-1]);
            x.v      = (k <= 10) ? (sels[k-1] < k) : (sels[k-1] <= 10);
            x.rk     = x.v ? mrk[sels[k-1]] : 128'h0;
`ifdef KEYEXP_ZEROIZE_EN
            x.chk_rk = 1'b1;
`else
            x.chk_rk = x.v || (sels[k-1] > 10);
`endif
            sbq.push_back(x);
            cyc();
            e = sbq.pop_front();
            n_checks++;
            if (rk_valid !== e.v) begin n_fail++; $display("FAIL midexp_valid[k=%0d,sel=%0d]: got %b want %b", k, sels[k-1], rk_valid, e.v); end
            if (e.chk_rk) begin
                n_checks++;
                if (rk_out !== e.rk) begin n_fail++; $display("FAIL midexp_rk[k=%0d,sel=%0d]: got %h want %h", k, sels[k-1], rk_out, e.rk); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] kk;
        int nb = 0;
        int ready_at = -1;
        key_load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            kk = rnd_key();
            key_in = kk;
            cyc();
            if (i > 0) begin
                n_checks += 2;
                if (busy !== 1'b1)       begin n_fail++; $display("FAIL b2b_busy[%0d]: got %b want 1", i, busy); end
                if (keys_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 0", i, keys_ready); end
            end
        end
        key_load = 1'b0;
        model_expand(kk);
        for (int k = 1; k <= 14; k++) begin
            if (busy === 1'b1) nb++;
            if (keys_ready === 1'b1 && ready_at < 0) ready_at = k;
            cyc();
        end
        n_checks += 2;
        if (nb != 10)       begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 10", nb); end
        if (ready_at != 11) begin n_fail++; $display("FAIL b2b_ready_cycle: got %0d want 11", ready_at); end
        for (int s = 0; s <= 10; s++) begin
            rk_sel = 4'(s);
            sbq.push_back(done_exp(s));
            cyc();
            e = sbq.pop_front();
            n_checks++;
            if (rk_out !== e.rk) begin n_fail++; $display("FAIL b2b_rk[%0d]: got %h want %h", s, rk_out, e.rk); end
        end
    endtask

`ifdef KEYEXP_ZEROIZE_EN
    task automatic test_zeroize();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int s = 0; s <= 10; s++) begin
            rk_sel = 4'(s);
            sbq.push_back('{rk: 128'h0, v: 1'b0, chk_rk: 1'b1});
            cyc();
            e = sbq.pop_front();
            n_checks += 2;
            if (rk_out !== e.rk)  begin n_fail++; $display("FAIL zeroize_rk[%0d]: got %h want %h", s, rk_out, e.rk); end
            if (rk_valid !== e.v) begin n_fail++; $display("FAIL zeroize_valid[%0d]: got %b want %b", s, rk_valid, e.v); end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; key_load = 1'b0; key_in = 128'h0; rk_sel = 4'd0;
        build_sbox();
        test_reset();
        test_fips_expand();
        test_read_sweep();
        test_reload_mid();
        test_reset_mid();
        test_midexp_read();
        test_back_to_back();
`ifdef KEYEXP_ZEROIZE_EN
        test_zeroize();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
